// File: rtl/parking_day_logger.sv
// ============================================================================
// Module   : parking_day_logger
// Purpose  : Per-hour arrival log, rush-hour window capture and end-of-day
//            report reader for the parking lot simulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_day_logger #(
    parameter int HOURS = 8,
    parameter int CNT_W = 4,
    parameter int HW    = $clog2(HOURS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hour_adv,
    input  logic             car_in,
    input  logic             lot_full,
    input  logic             lot_empty,
    input  logic             rd_next,
    output logic [HW-1:0]    hour,
    output logic             day_done,
    output logic [HW-1:0]    rush_start,
    output logic             rush_start_vld,
    output logic [HW-1:0]    rush_end,
    output logic             rush_end_vld,
    output logic [HW-1:0]    rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_valid
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [HW-1:0]    c_last_hour = HW'(HOURS - 1);

    typedef enum logic [0:0] {
        ST_COUNT  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hour_q, hour_d;
    logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
    logic [CNT_W-1:0] log_q [HOURS];
    logic [CNT_W-1:0] log_d [HOURS];
    logic [HW-1:0]    rush_start_q, rush_start_d;
    logic             rush_start_vld_q, rush_start_vld_d;
    logic [HW-1:0]    rush_end_q, rush_end_d;
    logic             rush_end_vld_q, rush_end_vld_d;
    logic [HW-1:0]    rd_idx_q, rd_idx_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_rd_count;

    // Saturating count including any car arriving this cycle.
    assign w_cnt_inc = (cur_cnt_q == c_cnt_max) ? c_cnt_max
                                                : cur_cnt_q + CNT_W'(car_in);

    always_comb begin
        state_d          = state_q;
        hour_d           = hour_q;
        cur_cnt_d        = cur_cnt_q;
        log_d            = log_q;
        rush_start_d     = rush_start_q;
        rush_start_vld_d = rush_start_vld_q;
        rush_end_d       = rush_end_q;
        rush_end_vld_d   = rush_end_vld_q;
        rd_idx_d         = rd_idx_q;

        if (state_q == ST_COUNT) begin
            cur_cnt_d = w_cnt_inc;
            if (hour_adv) begin
                for (int i = 0; i < HOURS; i++) begin
                    if (hour_q == HW'(i)) begin
                        log_d[i] = w_cnt_inc;
                    end
                end
                cur_cnt_d = '0;
                if (hour_q == c_last_hour) begin
                    state_d = ST_REPORT;
                end else begin
                    hour_d = hour_q + 1'b1;
                end
            end

            // End capture keys off the registered start flag, so a start
            // captured this cycle cannot also close the window.
            if (!rush_start_vld_q && lot_full) begin
                rush_start_d     = hour_q;
                rush_start_vld_d = 1'b1;
            end else if (rush_start_vld_q && !rush_end_vld_q && lot_empty) begin
                rush_end_d     = hour_q;
                rush_end_vld_d = 1'b1;
            end
        end else begin
            if (rd_next) begin
                rd_idx_d = (rd_idx_q == c_last_hour) ? '0 : rd_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_COUNT;
            hour_q           <= '0;
            cur_cnt_q        <= '0;
            for (int i = 0; i < HOURS; i++) begin
                log_q[i] <= '0;
            end
            rush_start_q     <= '0;
            rush_start_vld_q <= 1'b0;
            rush_end_q       <= '0;
            rush_end_vld_q   <= 1'b0;
            rd_idx_q         <= '0;
        end else begin
            state_q          <= state_d;
            hour_q           <= hour_d;
            cur_cnt_q        <= cur_cnt_d;
            log_q            <= log_d;
            rush_start_q     <= rush_start_d;
            rush_start_vld_q <= rush_start_vld_d;
            rush_end_q       <= rush_end_d;
            rush_end_vld_q   <= rush_end_vld_d;
            rd_idx_q         <= rd_idx_d;
        end
    end

    // Zero-latency report read; forced to zero outside REPORT.
    always_comb begin
        w_rd_count = '0;
        if (state_q == ST_REPORT) begin
            for (int i = 0; i < HOURS; i++) begin
                if (rd_idx_q == HW'(i)) begin
                    w_rd_count = log_q[i];
                end
            end
        end
    end

    assign hour           = hour_q;
    assign day_done       = (state_q == ST_REPORT);
    assign rd_valid       = (state_q == ST_REPORT);
    assign rush_start     = rush_start_q;
    assign rush_start_vld = rush_start_vld_q;
    assign rush_end       = rush_end_q;
    assign rush_end_vld   = rush_end_vld_q;
    assign rd_idx         = rd_idx_q;
    assign rd_count       = w_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_parking_day_logger.sv
// ============================================================================
// Module   : tb_parking_day_logger
// Purpose  : Directed and randomized bench for parking_day_logger with an
//            arithmetic reference model of the day log and report reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_day_logger;

    localparam int HOURS = 8;
    localparam int CNT_W = 4;
    localparam int HW    = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             hour_adv = 1'b0;
    logic             car_in = 1'b0;
    logic             lot_full = 1'b0;
    logic             lot_empty = 1'b0;
    logic             rd_next = 1'b0;
    logic [HW-1:0]    hour;
    logic             day_done;
    logic [HW-1:0]    rush_start;
    logic             rush_start_vld;
    logic [HW-1:0]    rush_end;
    logic             rush_end_vld;
    logic [HW-1:0]    rd_idx;
    logic [CNT_W-1:0] rd_count;
    logic             rd_valid;

    int vectors = 0;
    int miscompares = 0;

    parking_day_logger #(.HOURS(HOURS), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .hour_adv       (hour_adv),
        .car_in         (car_in),
        .lot_full       (lot_full),
        .lot_empty      (lot_empty),
        .rd_next        (rd_next),
        .hour           (hour),
        .day_done       (day_done),
        .rush_start     (rush_start),
        .rush_start_vld (rush_start_vld),
        .rush_end       (rush_end),
        .rush_end_vld   (rush_end_vld),
        .rd_idx         (rd_idx),
        .rd_count       (rd_count),
        .rd_valid       (rd_valid)
    );

    always #5 clk = ~clk;

    // Reference model: the day as plain integers.
    int m_log [HOURS];
    int m_hour, m_cnt, m_rd;
    int m_rs, m_re;
    bit m_rs_v, m_re_v, m_done, m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_log[i]) m_log[i] = 0;
            m_hour = 0; m_cnt = 0; m_rd = 0;
            m_rs = 0; m_re = 0; m_rs_v = 0; m_re_v = 0; m_done = 0;
            m_valid = 1'b1;
        end else if (!m_done) begin
            bit had_start;
            int closing;
            had_start = m_rs_v;
            if (!had_start && lot_full) begin
                m_rs = m_hour; m_rs_v = 1;
            end
            if (had_start && !m_re_v && lot_empty) begin
                m_re = m_hour; m_re_v = 1;
            end
            closing = m_cnt + int'(car_in);
            if (closing > MAXC) closing = MAXC;
            if (hour_adv) begin
                m_log[m_hour] = closing;
                m_cnt = 0;
                if (m_hour == HOURS - 1) m_done = 1;
                else m_hour = m_hour + 1;
            end else begin
                m_cnt = closing;
            end
        end else if (rd_next) begin
            m_rd = (m_rd + 1) % HOURS;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("hour",           int'(hour),           m_hour);
            chk("day_done",       int'(day_done),       int'(m_done));
            chk("rd_valid",       int'(rd_valid),       int'(m_done));
            chk("rush_start",     int'(rush_start),     m_rs);
            chk("rush_start_vld", int'(rush_start_vld), int'(m_rs_v));
            chk("rush_end",       int'(rush_end),       m_re);
            chk("rush_end_vld",   int'(rush_end_vld),   int'(m_re_v));
            chk("rd_idx",         int'(rd_idx),         m_done ? m_rd : 0);
            chk("rd_count",       int'(rd_count),       m_done ? m_log[m_rd] : 0);
        end
    end

    task automatic cyc(input bit ha, input bit c, input bit f, input bit e,
                       input bit rn, input bit rs);
        hour_adv = ha; car_in = c; lot_full = f; lot_empty = e;
        rd_next = rn; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        idle();
    endtask

    task automatic finish_day();
        for (int k = 0; k < 2 * HOURS && !day_done; k++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        do_reset();
        chk("lit_reset_hour", int'(hour), 0);
        chk("lit_reset_done", int'(day_done), 0);
        chk("lit_reset_rdcnt", int'(rd_count), 0);

        // Basic day: h+1 cars in hour h.
        for (int h = 0; h < HOURS; h++) begin
            for (int c = 0; c <= h; c++) cyc(0, 1, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0);
        end
        chk("lit_basic_done", int'(day_done), 1);
        for (int i = 0; i < HOURS; i++) begin
            chk("lit_basic_idx", int'(rd_idx), i);
            chk("lit_basic_cnt", int'(rd_count), i + 1);
            cyc(0, 0, 0, 0, 1, 0);
        end
        // Report mode ignores day inputs; 9 steps from 0 lands on 1.
        for (int i = 0; i < 9; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
            cyc(1'($urandom), 1'($urandom), 0, 0, 0, 0);
        end
        chk("lit_wrap_idx", int'(rd_idx), 1);
        chk("lit_wrap_cnt", int'(rd_count), 2);
        chk("lit_wrap_hour", int'(hour), HOURS - 1);

        // Saturation.
        do_reset();
        for (int c = 0; c < 20; c++) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        finish_day();
        chk("lit_sat_log0", int'(rd_count), 15);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_sat_log1", int'(rd_count), 0);

        // Coincident car_in with hour_adv.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        finish_day();
        chk("lit_coin_log0", int'(rd_count), 3);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_coin_log1", int'(rd_count), 0);

        // Rush window.
        do_reset();
        cyc(0, 0, 0, 1, 0, 0); cyc(1, 0, 0, 0, 0, 0);   // hour 0: empty ignored
        cyc(1, 0, 0, 0, 0, 0);                          // hour 1
        cyc(0, 0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);   // hour 2: full
        cyc(0, 0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);   // hour 3: full again
        cyc(1, 0, 0, 0, 0, 0);                          // hour 4
        cyc(0, 0, 0, 1, 0, 0); cyc(1, 0, 0, 0, 0, 0);   // hour 5: empty
        cyc(0, 0, 1, 1, 0, 0); cyc(1, 0, 0, 0, 0, 0);   // hour 6: both
        cyc(1, 0, 0, 0, 0, 0);                          // hour 7
        chk("lit_rush_start", int'(rush_start), 2);
        chk("lit_rush_svld", int'(rush_start_vld), 1);
        chk("lit_rush_end", int'(rush_end), 5);
        chk("lit_rush_evld", int'(rush_end_vld), 1);

        // Reset mid-day at hour 4, then mid-report.
        do_reset();
        for (int h = 0; h < 4; h++) begin
            cyc(0, 1, 1, 0, 0, 0);
            cyc(1, 1, 0, 1, 0, 0);
        end
        chk("lit_mid_hour4", int'(hour), 4);
        cyc(0, 0, 0, 0, 0, 1);
        chk("lit_mid_hour0", int'(hour), 0);
        chk("lit_mid_svld", int'(rush_start_vld), 0);
        finish_day();
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("lit_rep_done", int'(day_done), 0);
        chk("lit_rep_idx", int'(rd_idx), 0);
        finish_day();
        for (int i = 0; i < HOURS; i++) begin
            chk("lit_fresh_log", int'(rd_count), 0);
            cyc(0, 0, 0, 0, 1, 0);
        end

        // Randomized days with occasional resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 5) == 0), 1'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                1'($urandom), ($urandom_range(0, 299) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/parking_day_logger.md
# parking_day_logger

Per-hour traffic logger and end-of-day report reader for the parking lot simulator. During the simulated day it counts car arrivals per hour and stores each hour's total in a small register-file log. It also captures the rush-hour window from the lot's full/empty flags. After the final hour closes it switches to report mode, where the display logic steps through the stored log one entry at a time.

## Interface
Parameters:
- HOURS, default 8: hours per simulated day; must be ≥2; HW = $clog2(HOURS)
- CNT_W, default 4: width of each per-hour arrival count; counts saturate at 2^CNT_W-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hour_adv  in  1  one-cycle pulse; closes the current hour
- car_in  in  1  one-cycle pulse; a car entered
- lot_full  in  1  level; lot occupancy at capacity
- lot_empty  in  1  level; lot occupancy zero
- rd_next  in  1  one-cycle pulse; advance the report pointer (REPORT state only)
- hour  out  HW  current hour index, 0..HOURS-1
- day_done  out  1  high while in REPORT
- rush_start  out  HW  hour in which lot_full was first seen
- rush_start_vld  out  1  rush_start has been captured
- rush_end  out  HW  hour in which lot_empty was first seen after the rush start
- rush_end_vld  out  1  rush_end has been captured
- rd_idx  out  HW  report pointer
- rd_count  out  CNT_W  log entry at rd_idx
- rd_valid  out  1  rd_idx/rd_count are meaningful (same as day_done)

## Operation
- FSM has two states: COUNT (reset state) and REPORT.
- COUNT, arrival counting:
  - cur_cnt (CNT_W bits) increments on car_in and saturates at 2^CNT_W-1.
- COUNT, on hour_adv:
  - log[hour] is written with sat(cur_cnt + car_in). A car_in coincident with hour_adv counts toward the hour being closed.
  - cur_cnt clears to 0.
  - If hour < HOURS-1, hour increments.
  - If hour == HOURS-1, hour holds at HOURS-1 and the FSM goes to REPORT.
- COUNT, rush capture:
  - Start: if !rush_start_vld && lot_full, then rush_start <= hour and rush_start_vld <= 1.
  - End: if rush_start_vld && !rush_end_vld && lot_empty, then rush_end <= hour and rush_end_vld <= 1.
  - lot_empty seen before the start is captured is ignored.
  - On the cycle the start is captured, lot_empty is not evaluated for the end.
  - Both captures are write-once per day.
- REPORT:
  - day_done = rd_valid = 1.
  - rd_count = log[rd_idx], combinational from the registered log.
  - rd_next increments rd_idx, wrapping HOURS-1 -> 0.
  - car_in, hour_adv, lot_full and lot_empty are ignored; log, hour and rush outputs hold.
  - Only reset leaves REPORT.
- Outside REPORT: rd_idx = 0, rd_count = 0, rd_valid = 0.
- Reset values: state COUNT, hour 0, cur_cnt 0, all log entries 0, day_done 0, rush_start 0, rush_end 0, both vld flags 0, rd_idx 0, rd_count 0, rd_valid 0.

## Timing
- All state updates on posedge clk. Reset has priority over every other input.
- hour, log entry and cur_cnt update on the same edge that samples hour_adv.
- day_done rises in the cycle after the edge that samples the final hour_adv (the hour-(HOURS-1) close).
- Rush flags are visible the cycle after the sampling edge.
- Report reads: rd_count follows rd_idx in the same cycle, with zero read latency. One rd_next gives exactly one pointer step.
- Reset asserted mid-day or mid-report: all outputs and the log hold reset values from the next cycle; the day restarts at hour 0.

## Test plan
- Basic day: reset, then per hour h issue h+1 car_in pulses and one hour_adv, for 8 hours. Required: day_done=1 after the 8th hour_adv. Stepping rd_next reads rd_count = 1,2,...,8 at rd_idx 0..7.
- Saturation: 20 car_in in hour 0 (CNT_W=4), then hour_adv. Required: log[0]=15; hour-1 count starts from 0.
- Coincident pulse: 2 car_in, then car_in together with hour_adv. Required: log[0]=3 and cur_cnt=0 for hour 1.
- Rush window:
  - Stimulus: lot_empty in hour 0, lot_full in hours 2-3, lot_empty in hour 5, lot_full again in hour 6.
  - Required: rush_start=2 (vld), rush_end=5 (vld), both unchanged afterward.
- Report behaviour: in REPORT apply 9 rd_next pulses and random car_in/hour_adv. Required: rd_idx wraps 7 -> 0 and ends at 1; log and hour unchanged.
- Reset mid-operation: reset at hour 4, then again in REPORT. Required: next cycle hour=0, day_done=0, rush flags 0, all log entries read back 0 after a fresh day.
